// File: rtl/iot_event_sequencer.sv
// Join/leave event sequencer feeding the active-device monitor: filters, queues and round-robin issues events.
// Optional drop counter enabled by defining IOT_SEQ_DROP_CNT_EN.
module iot_event_sequencer #(
    parameter int N_DEV = 8,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_join,
    input  logic [N_DEV-1:0] dev_leave,
    input  logic             stall,
    output logic             on_off,
    output logic             change,
    output logic [ID_W-1:0]  dev_id,
    output logic [N_DEV-1:0] active_mask,
    output logic             pending
`ifdef IOT_SEQ_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    localparam logic [ID_W:0] N_W = (ID_W+1)'(N_DEV);

    logic [N_DEV-1:0] p_q;
    logic [N_DEV-1:0] d_q;
    logic [ID_W-1:0]  rr_ptr;

    logic             gnt_vld;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  rr_next;
    logic [N_DEV-1:0] a_g;
    logic [N_DEV-1:0] p_g;
    logic [N_DEV-1:0] p_nxt;
    logic [N_DEV-1:0] d_nxt;
`ifdef IOT_SEQ_DROP_CNT_EN
    logic [5:0]       drop_sum;
    logic [8:0]       drop_tot;
`endif

    // Round-robin search over registered pending flags, starting at rr_ptr.
    always_comb begin
        logic [ID_W:0] idx;
        logic          found;
        idx     = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_DEV; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= N_W)
                idx = idx - N_W;
            if (!found && p_q[idx[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = idx[ID_W-1:0];
            end
        end
        gnt_vld = found && !stall;
        idx     = {1'b0, gnt_idx} + (ID_W+1)'(1);
        rr_next = (idx >= N_W) ? '0 : idx[ID_W-1:0];
    end

    // Intake sees the state as it will be after this edge's grant.
    always_comb begin
        logic e;
        e     = 1'b0;
        a_g   = active_mask;
        p_g   = p_q;
        if (gnt_vld) begin
            a_g[gnt_idx] = d_q[gnt_idx];
            p_g[gnt_idx] = 1'b0;
        end
        p_nxt = p_g;
        d_nxt = d_q;
`ifdef IOT_SEQ_DROP_CNT_EN
        drop_sum = '0;
`endif
        for (int i = 0; i < N_DEV; i++) begin
            e = p_g[i] ? d_q[i] : a_g[i];
            if (dev_join[i] && dev_leave[i]) begin
`ifdef IOT_SEQ_DROP_CNT_EN
                drop_sum = drop_sum + 6'd1;
`endif
            end else if (dev_join[i]) begin
                if (!e) begin
                    if (p_g[i]) begin
                        p_nxt[i] = 1'b0;
                    end else begin
                        p_nxt[i] = 1'b1;
                        d_nxt[i] = 1'b1;
                    end
                end else begin
`ifdef IOT_SEQ_DROP_CNT_EN
                    drop_sum = drop_sum + 6'd1;
`endif
                end
            end else if (dev_leave[i]) begin
                if (e) begin
                    if (p_g[i]) begin
                        p_nxt[i] = 1'b0;
                    end else begin
                        p_nxt[i] = 1'b1;
                        d_nxt[i] = 1'b0;
                    end
                end else begin
`ifdef IOT_SEQ_DROP_CNT_EN
                    drop_sum = drop_sum + 6'd1;
`endif
                end
            end
        end
`ifdef IOT_SEQ_DROP_CNT_EN
        drop_tot = {1'b0, drop_cnt} + 9'(drop_sum);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on_off      <= 1'b0;
            change      <= 1'b0;
            dev_id      <= '0;
            active_mask <= '0;
            pending     <= 1'b0;
            p_q         <= '0;
            d_q         <= '0;
            rr_ptr      <= '0;
`ifdef IOT_SEQ_DROP_CNT_EN
            drop_cnt    <= '0;
`endif
        end else begin
            on_off <= gnt_vld;
            if (gnt_vld) begin
                change <= d_q[gnt_idx];
                dev_id <= gnt_idx;
                rr_ptr <= rr_next;
            end
            active_mask <= a_g;
            p_q         <= p_nxt;
            d_q         <= d_nxt;
            pending     <= |p_nxt;
`ifdef IOT_SEQ_DROP_CNT_EN
            drop_cnt    <= (drop_tot > 9'd255) ? 8'hFF : drop_tot[7:0];
`endif
        end
    end

endmodule

// File: tb/tb_iot_event_sequencer.sv
// Bench for iot_event_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_iot_event_sequencer;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] dev_join;
    logic [N-1:0] dev_leave;
    logic         stall;
    logic         on_off;
    logic         change;
    logic [2:0]   dev_id;
    logic [N-1:0] active_mask;
    logic         pending;
`ifdef IOT_SEQ_DROP_CNT_EN
    logic [7:0]   drop_cnt;
`endif

    iot_event_sequencer #(.N_DEV(N), .ID_W(3)) dut (
        .clk(clk), .rst(rst), .dev_join(dev_join), .dev_leave(dev_leave), .stall(stall),
        .on_off(on_off), .change(change), .dev_id(dev_id), .active_mask(active_mask),
        .pending(pending)
`ifdef IOT_SEQ_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-device active / pending / direction arrays.
    bit mA[N], mP[N], mD[N];
    int mrr, exp_id, exp_drop, bal;
    bit exp_on, exp_chg;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mask_of(input bit v[N]);
        int m = 0;
        for (int i = 0; i < N; i++) if (v[i]) m |= (1 << i);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin mA[i] = 0; mP[i] = 0; mD[i] = 0; end
        mrr = 0; exp_id = 0; exp_drop = 0; exp_on = 0; exp_chg = 0; bal = 0;
    endtask

    task automatic model_step();
        int drops;
        bit e;
        if (!rst) begin
            model_reset();
            return;
        end
        exp_on = 0;
        if (!stall) begin
            for (int k = 0; k < N; k++) begin
                int i = (mrr + k) % N;
                if (mP[i]) begin
                    exp_on = 1; exp_chg = mD[i]; exp_id = i;
                    mA[i] = mD[i]; mP[i] = 0; mrr = (i + 1) % N;
                    break;
                end
            end
        end
        drops = 0;
        for (int i = 0; i < N; i++) begin
            e = mP[i] ? mD[i] : mA[i];
            if (dev_join[i] && dev_leave[i]) drops++;
            else if (dev_join[i] || dev_leave[i]) begin
                bit want = dev_join[i];
                if (e == want) drops++;
                else if (mP[i]) mP[i] = 0;
                else begin mP[i] = 1; mD[i] = want; end
            end
        end
        exp_drop = (exp_drop + drops > 255) ? 255 : exp_drop + drops;
    endtask

    task automatic compare_all();
        int pend = 0;
        for (int i = 0; i < N; i++) if (mP[i]) pend = 1;
        chk("on_off", on_off, exp_on);
        chk("change", change, exp_chg);
        chk("dev_id", dev_id, exp_id);
        chk("active_mask", active_mask, mask_of(mA));
        chk("pending", pending, pend);
`ifdef IOT_SEQ_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, exp_drop);
`endif
        if (!rst) bal = 0;
        else if (on_off) bal += change ? 1 : -1;
        chk("strobe_balance", bal, $countones(active_mask));
    endtask

    // Inputs are applied at the falling edge; outputs are compared at the next falling edge.
    task automatic cycle(input logic [N-1:0] j, input logic [N-1:0] l, input logic s);
        dev_join = j; dev_leave = l; stall = s;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; dev_join = '1; dev_leave = '0; stall = 1'b0;
        model_reset();
        @(negedge clk);
        // 1: reset holds everything low even with pulses present
        cycle(8'hFF, 8'h00, 1'b0);
        cycle(8'h00, 8'hFF, 1'b0);
        chk("t1_on_off", on_off, 0);
        chk("t1_dev_id", dev_id, 0);
        chk("t1_mask", active_mask, 8'h00);
        chk("t1_pending", pending, 0);
        rst = 1'b1;
        cycle(8'h00, 8'h00, 1'b0);
        chk("t1_first_edge_no_strobe", on_off, 0);

        // 2: single join
        cycle(8'h08, 8'h00, 1'b0);
        chk("t2_no_strobe_yet", on_off, 0);
        cycle(8'h00, 8'h00, 1'b0);
        chk("t2_on_off", on_off, 1);
        chk("t2_change", change, 1);
        chk("t2_dev_id", dev_id, 3);
        chk("t2_mask", active_mask, 8'h08);
        cycle(8'h00, 8'h00, 1'b0);
        chk("t2_on_off_low", on_off, 0);

        // 3: three joins from rr_ptr=4
        cycle(8'h62, 8'h00, 1'b0);
        chk("t3_pending", pending, 1);
        cycle(8'h00, 8'h00, 1'b0);
        chk("t3_id_a", dev_id, 5);
        cycle(8'h00, 8'h00, 1'b0);
        chk("t3_id_b", dev_id, 6);
        cycle(8'h00, 8'h00, 1'b0);
        chk("t3_id_c", dev_id, 1);
        chk("t3_on_c", on_off, 1);
        chk("t3_change_c", change, 1);
        chk("t3_mask", active_mask, 8'h6A);

        // 4: two leaves from rr_ptr=2, second wraps
        cycle(8'h00, 8'h42, 1'b0);
        cycle(8'h00, 8'h00, 1'b0);
        chk("t4_id_a", dev_id, 6);
        chk("t4_change_a", change, 0);
        cycle(8'h00, 8'h00, 1'b0);
        chk("t4_id_b", dev_id, 1);
        chk("t4_change_b", change, 0);
        chk("t4_mask", active_mask, 8'h28);

        // 5: cancellation and redundancy under stall
        cycle(8'h04, 8'h00, 1'b1);
        chk("t5_pending_set", pending, 1);
        cycle(8'h00, 8'h04, 1'b1);
        chk("t5_pending_cancel", pending, 0);
        chk("t5_on_off_a", on_off, 0);
        cycle(8'h20, 8'h00, 1'b1);
        chk("t5_pending_drop", pending, 0);
`ifdef IOT_SEQ_DROP_CNT_EN
        chk("t5_drop_cnt", drop_cnt, 1);
`endif
        cycle(8'h00, 8'h00, 1'b0);
        chk("t5_release_no_strobe", on_off, 0);

        // 6: two pending held by stall, then back-to-back, then reset mid-burst
        cycle(8'h81, 8'h00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(8'h00, 8'h00, 1'b1);
            chk("t6_stalled", on_off, 0);
        end
        cycle(8'h00, 8'h00, 1'b0);
        chk("t6_first_on", on_off, 1);
        chk("t6_first_id", dev_id, 7);
        cycle(8'h00, 8'h00, 1'b0);
        chk("t6_second_on", on_off, 1);
        chk("t6_second_id", dev_id, 0);
        chk("t6_mask", active_mask, 8'hA9);
        cycle(8'h16, 8'h00, 1'b1);
        cycle(8'h00, 8'h00, 1'b0);
        chk("t6_burst_on", on_off, 1);
        async_reset();
        chk("t6_rst_pending", pending, 0);
        chk("t6_rst_on", on_off, 0);
        cycle(8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(8'h00, 8'h00, 1'b0);
            chk("t6_after_rst", on_off, 0);
        end

        // Randomized traffic with sparse pulses and occasional stalls
        for (int n = 0; n < 3000; n++) begin
            logic [N-1:0] j, l;
            j = 8'($urandom & $urandom & $urandom);
            l = 8'($urandom & $urandom & $urandom);
            if (n == 1500) begin
                async_reset();
                cycle(j, l, 1'b0);
                rst = 1'b1;
            end else begin
                cycle(j, l, ($urandom_range(0, 3) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
